// File: rtl/main_net_train_sequencer.sv
// Drives main_net start/done handshakes for a programmed number of iterations, requesting a target sync every TARGET_UPDATE_PERIOD passes.
// Waits on main_net completion and target-sync ack; optional pass watchdog via MAIN_NET_SEQ_WATCHDOG_EN.
module main_net_train_sequencer #(
    parameter int ITER_WIDTH           = 16,
    parameter int TARGET_UPDATE_PERIOD = 8,
    parameter int TIMEOUT_CYCLES       = 4096,
    parameter int TIMEOUT_WIDTH        = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [ITER_WIDTH-1:0] i_num_iter,
    output logic                  o_net_valid,
    input  logic                  i_net_valid,
    output logic                  o_sync_req,
    input  logic                  i_sync_ack,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic [ITER_WIDTH-1:0] o_iter_count
);

    if ((TIMEOUT_WIDTH < $clog2(TIMEOUT_CYCLES + 1)) || (TARGET_UPDATE_PERIOD < 1)) begin : g_bad_cfg
        $error("main_net_train_sequencer: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_SYNC,
        S_FINISH
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ITER_WIDTH-1:0] r_num_iter;
    logic [ITER_WIDTH-1:0] r_iter_cnt;
    logic [ITER_WIDTH-1:0] r_sync_cnt;
    logic                  w_accept;
    logic                  w_net_done;
    logic                  w_sync_hit;
    logic                  w_last;
    logic                  w_all_done;
    logic                  w_wd_expire;

    assign w_accept   = (r_state == S_IDLE) && i_start;
    assign w_net_done = (r_state == S_WAIT) && i_net_valid;
    assign w_sync_hit = (r_sync_cnt + ITER_WIDTH'(1)) == ITER_WIDTH'(TARGET_UPDATE_PERIOD);
    assign w_last     = (r_iter_cnt + ITER_WIDTH'(1)) == r_num_iter;
    assign w_all_done = r_iter_cnt == r_num_iter;

`ifdef MAIN_NET_SEQ_WATCHDOG_EN
    logic [TIMEOUT_WIDTH-1:0] r_wd_cnt;
    logic                     r_timeout;

    // A completion on the expiry cycle takes priority over the timeout.
    assign w_wd_expire = (r_state == S_WAIT) && !i_net_valid &&
                         (r_wd_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == S_LAUNCH) begin
                r_wd_cnt <= '0;
            end else if ((r_state == S_WAIT) && !i_net_valid) begin
                r_wd_cnt <= r_wd_cnt + TIMEOUT_WIDTH'(1);
            end
            if (w_accept) begin
                r_timeout <= 1'b0;
            end else if (w_wd_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_wd_expire = 1'b0;
    assign o_timeout   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_num_iter == '0) ? S_FINISH : S_LAUNCH;
                end
            end
            S_LAUNCH: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_net_valid) begin
                    if (w_sync_hit) begin
                        w_state_nxt = S_SYNC;
                    end else if (w_last) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_state_nxt = S_LAUNCH;
                    end
                end else if (w_wd_expire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SYNC: begin
                if (i_sync_ack) begin
                    w_state_nxt = w_all_done ? S_FINISH : S_LAUNCH;
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_iter <= '0;
            r_iter_cnt <= '0;
            r_sync_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_num_iter <= i_num_iter;
                r_iter_cnt <= '0;
                r_sync_cnt <= '0;
            end else if (w_net_done) begin
                r_iter_cnt <= r_iter_cnt + ITER_WIDTH'(1);
                r_sync_cnt <= w_sync_hit ? '0 : r_sync_cnt + ITER_WIDTH'(1);
            end
        end
    end

    assign o_net_valid  = (r_state == S_LAUNCH);
    assign o_sync_req   = (r_state == S_SYNC);
    assign o_done       = (r_state == S_FINISH);
    assign o_busy       = (r_state != S_IDLE);
    assign o_iter_count = r_iter_cnt;

endmodule
